// File: rtl/id_inst_queue_pkg.sv
// ==========================================================================
// id_inst_queue_pkg : shared entry layout and stall encodings  | rev 1.0
// ==========================================================================
`default_nettype none

package id_inst_queue_pkg;

  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_ID   = 2'd1,
    STALL_EX   = 2'd2,
    STALL_MEM  = 2'd3
  } stall_e;

endpackage

`default_nettype wire

// File: rtl/id_q_ram.sv
// ==========================================================================
// id_q_ram : DEPTH x 64 register array, one write, one async read  | rev 1.0
// ==========================================================================
`default_nettype none

module id_q_ram
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/id_inst_queue.sv
// ==========================================================================
// id_inst_queue : IF->ID instruction queue with branch delay-slot flush | rev 1.0
// ==========================================================================
`default_nettype none

module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam bit            KEEP_SLOT = (DELAY_SLOT != 0);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          slot_pending, drop_pending;

  logic   push, pop, branch_flush, keep_slot_push, ram_we;
  entry_t wr_entry, head;

  assign in_ready  = (count_q < DEPTH_C) & ~drop_pending;
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign branch_flush = flush & pop;

  // A push survives a flush only when it becomes the delay slot of the popped branch.
  assign keep_slot_push = branch_flush & KEEP_SLOT & (count_q == ONE_C) & push;
  assign ram_we         = push & (~flush | keep_slot_push);

  assign wr_entry = '{pc: in_pc, inst: in_inst};

  id_q_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Empty slots read as zero so reset leaves a clean head.
  assign out_pc   = out_valid ? head.pc   : 32'd0;
  assign out_inst = out_valid ? head.inst : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      slot_pending <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      drop_pending <= 1'b0;
      if (flush) begin
        slot_pending <= 1'b0;
        if (branch_flush && KEEP_SLOT) begin
          rd_ptr <= rd_ptr + PW'(1);
          if (count_q > ONE_C) begin
            wr_ptr  <= rd_ptr + PW'(2);
            count_q <= ONE_C;
          end else if (push) begin
            wr_ptr  <= wr_ptr + PW'(1);
            count_q <= ONE_C;
          end else begin
            count_q      <= '0;
            slot_pending <= 1'b1;
          end
        end else begin
          rd_ptr  <= wr_ptr;
          count_q <= '0;
        end
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + ONE_C;
          2'b01:   count_q <= count_q - ONE_C;
          default: count_q <= count_q;
        endcase
        // The fetch already in flight behind the delay slot is stale.
        if (slot_pending && push) begin
          slot_pending <= 1'b0;
          drop_pending <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_inst_queue.sv
// ==========================================================================
// tb_id_inst_queue : directed self-checking bench for id_inst_queue | rev 1.0
// ==========================================================================
`default_nettype none

module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  id_inst_queue #(.DEPTH(4), .DELAY_SLOT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle just after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = ~pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_count",     32'(count),     0);
    chk("reset_in_ready",  32'(in_ready),  1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_pc",    out_pc,         0);
    rst = 1'b0;

    // Fill to full, then a refused push
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(i * 4), 0, 0);
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_in_ready", 32'(in_ready), 0);
    step(1, 32'h100, 0, 0);
    chk("full_push_ignored", 32'(count), 4);
    chk("full_head_stable",  out_pc,     0);
    chk("full_head_inst",    out_inst,   32'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(i * 4));
      step(0, 0, 1, 0);
    end
    chk("drain_count", 32'(count),     0);
    chk("drain_valid", 32'(out_valid), 0);
    step(0, 0, 1, 0);
    chk("underflow_count", 32'(count), 0);

    // Steady push+pop at count=2 across pointer wrap
    step(1, 32'h40, 0, 0);
    step(1, 32'h44, 0, 0);
    chk("pp_start_count", 32'(count), 2);
    for (int i = 0; i < 10; i++) begin
      chk("pp_head_pc", out_pc, 32'h40 + 32'(4 * i));
      step(1, 32'h48 + 32'(4 * i), 1, 0);
      chk("pp_count", 32'(count), 2);
    end
    chk("pp_tail0", out_pc, 32'h68);
    step(0, 0, 1, 0);
    chk("pp_tail1", out_pc, 32'h6C);
    chk("pp_tail1_inst", out_inst, ~32'h6C);
    step(0, 0, 1, 0);
    chk("pp_empty", 32'(count), 0);

    // Branch flush keeps the delay slot only
    step(1, 32'h10, 0, 0);
    step(1, 32'h14, 0, 0);
    step(1, 32'h18, 0, 0);
    chk("bf_count3", 32'(count), 3);
    step(0, 0, 1, 1);
    chk("bf_count", 32'(count), 1);
    chk("bf_pc",    out_pc,     32'h14);
    step(0, 0, 1, 0);
    chk("bf_drained", 32'(count), 0);

    // Delay slot not yet fetched: slot_pending then one dropped fetch
    step(1, 32'h20, 0, 0);
    step(0, 0, 1, 1);
    chk("sp_count0",   32'(count),    0);
    chk("sp_in_ready", 32'(in_ready), 1);
    step(1, 32'h24, 0, 0);
    chk("sp_slot_kept", 32'(count),    1);
    chk("sp_slot_pc",   out_pc,        32'h24);
    chk("sp_drop_rdy",  32'(in_ready), 0);
    step(1, 32'h28, 0, 0);
    chk("sp_stale_refused", 32'(count),    1);
    chk("sp_pc_after",      out_pc,        32'h24);
    chk("sp_ready_back",    32'(in_ready), 1);
    step(0, 0, 1, 0);
    chk("sp_drained", 32'(count), 0);

    // Same-cycle push becomes the delay slot
    step(1, 32'h30, 0, 0);
    step(1, 32'h34, 1, 1);
    chk("ds_push_count", 32'(count), 1);
    chk("ds_push_pc",    out_pc,     32'h34);
    step(0, 0, 1, 0);
    chk("ds_push_drained", 32'(count), 0);

    // Full flush drops everything including the push
    step(1, 32'h50, 0, 0);
    step(1, 32'h54, 0, 0);
    step(1, 32'h58, 0, 0);
    step(1, 32'h5C, 0, 1);
    chk("ff_count", 32'(count),     0);
    chk("ff_valid", 32'(out_valid), 0);
    chk("ff_ready", 32'(in_ready),  1);

    // Reset mid-operation
    step(1, 32'h60, 0, 0);
    step(1, 32'h64, 0, 0);
    step(1, 32'h68, 0, 0);
    chk("rm_count3", 32'(count), 3);
    rst = 1'b1;
    step(1, 32'h6C, 1, 0);
    rst = 1'b0;
    chk("rm_count", 32'(count),    0);
    chk("rm_ready", 32'(in_ready), 1);
    chk("rm_pc",    out_pc,        0);
    step(1, 32'h70, 0, 0);
    chk("rm_after_pc",    out_pc,     32'h70);
    chk("rm_after_count", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
